// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES byte-serial input loader.
// Imported by the loader top and its shadow register.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_BITS  = 128;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

endpackage

// File: rtl/aes_input_loader_byte_shifter.sv
// 128-bit shadow register for frame assembly.
// One byte lane is written per cycle; clear wins over write.
module byte_shifter
    import aes_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      we,
    input  logic [3:0]                idx,
    input  logic [7:0]                din,
    output logic [AES_BLOCK_BITS-1:0] q
);

    logic [6:0] lsb;

    assign lsb = {idx, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            q <= '0;
        end else if (we) begin
            q[lsb +: 8] <= din;
        end
    end

endmodule

// File: rtl/aes_input_loader.sv
// Byte-serial key/plaintext frame loader for the AES-128 encrypt top.
// Frames assemble in a shadow register and publish only when complete.
module aes_input_loader
    import aes_pkg::*;
#(
    parameter int HOLD_CYCLES = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] key,
    output logic [127:0] plain_in,
    output logic         key_loaded,
    output logic         block_start,
    output logic         busy,
    output logic         frame_err
);

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);
    localparam logic [3:0] LAST_IDX  = 4'(AES_BLOCK_BYTES - 1);

    state_t                    state_q;
    state_t                    state_d;
    logic [3:0]                cnt_q;
    logic [3:0]                cnt_d;
    logic [7:0]                hold_q;
    logic [7:0]                hold_d;
    logic                      sel_q;
    logic                      sel_d;
    logic                      xfer;
    logic                      sh_we;
    logic                      sh_clr;
    logic                      key_we;
    logic                      plain_we;
    logic                      bs_d;
    logic                      err_d;
    logic [AES_BLOCK_BITS-1:0] shadow;
    logic [AES_BLOCK_BITS-1:0] full;

    // Ready depends on state (and reset) only, never on in_valid.
    assign in_ready = rst_n && (state_q != HOLD);
    assign busy     = (state_q == HOLD);
    assign xfer     = in_valid && in_ready;

    // Completed frame: byte 15 bypasses the shadow in its final cycle.
    assign full = {in_data, shadow[AES_BLOCK_BITS-9:0]};

    byte_shifter u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sh_clr),
        .we    (sh_we),
        .idx   (cnt_q),
        .din   (in_data),
        .q     (shadow)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        sel_d    = sel_q;
        sh_we    = 1'b0;
        sh_clr   = 1'b0;
        key_we   = 1'b0;
        plain_we = 1'b0;
        bs_d     = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    sh_we   = 1'b1;
                    sel_d   = in_sel;
                    cnt_d   = 4'd1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    if (in_sel != sel_q) begin
                        sh_clr  = 1'b1;
                        err_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else if (cnt_q == LAST_IDX) begin
                        sh_we   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                        if (sel_q) begin
                            key_we = 1'b1;
                        end else if (key_loaded) begin
                            plain_we = 1'b1;
                            bs_d     = 1'b1;
                            hold_d   = HOLD_INIT;
                            state_d  = HOLD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        sh_we = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                hold_d = hold_q - 8'd1;
                if (hold_q <= 8'd1) begin
                    hold_d  = 8'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            hold_q      <= 8'd0;
            sel_q       <= 1'b0;
            key         <= '0;
            plain_in    <= '0;
            key_loaded  <= 1'b0;
            block_start <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            sel_q       <= sel_d;
            block_start <= bs_d;
            frame_err   <= err_d;
            if (key_we) begin
                key        <= full;
                key_loaded <= 1'b1;
            end
            if (plain_we) begin
                plain_in <= full;
            end
        end
    end

endmodule

// File: tb/tb_aes_input_loader.sv
// Randomized and directed bench for aes_input_loader.
// A queue-based frame model predicts every output each cycle.
module tb_aes_input_loader;

    localparam int HOLD = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] plain_in;
    logic         key_loaded;
    logic         block_start;
    logic         busy;
    logic         frame_err;

    aes_input_loader #(.HOLD_CYCLES(HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .key         (key),
        .plain_in    (plain_in),
        .key_loaded  (key_loaded),
        .block_start (block_start),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]   fq[$];
    bit           fsel;
    bit           m_kl;
    logic [127:0] m_key;
    logic [127:0] m_plain;
    int           hold_left;
    bit           m_bs;
    bit           m_err;
    int           blocks;
    int           dut_blocks;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        fsel      = 1'b0;
        m_kl      = 1'b0;
        m_key     = '0;
        m_plain   = '0;
        hold_left = 0;
        m_bs      = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic model_xfer(bit s, logic [7:0] d);
        logic [127:0] word;
        if (fq.size() != 0 && s != fsel) begin
            m_err = 1'b1;
            fq.delete();
            return;
        end
        if (fq.size() == 0) fsel = s;
        fq.push_back(d);
        if (fq.size() == 16) begin
            word = '0;
            foreach (fq[i]) word[8*i +: 8] = fq[i];
            fq.delete();
            if (fsel) begin
                m_key = word;
                m_kl  = 1'b1;
            end else if (m_kl) begin
                m_plain   = word;
                m_bs      = 1'b1;
                hold_left = HOLD;
                blocks++;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("key", key, m_key);
        chk("plain_in", plain_in, m_plain);
        chk("key_loaded", key_loaded, m_kl);
        chk("block_start", block_start, m_bs);
        chk("busy", busy, hold_left > 0);
        chk("frame_err", frame_err, m_err);
        if (block_start === 1'b1) dut_blocks++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(bit v, bit s, logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
        chk("in_ready", in_ready, hold_left == 0);
        m_bs  = 1'b0;
        m_err = 1'b0;
        if (hold_left > 0) hold_left--;
        else if (v) model_xfer(s, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_cycles(int n);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'hA5;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("in_ready_rst", in_ready, 1'b0);
            model_reset();
            @(negedge clk);
            check_outputs();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(bit s, logic [7:0] base, int n, int mm);
        for (int i = 0; i < n; i++) begin
            step(1'b1, (i == mm) ? ~s : s, base + 8'(i));
        end
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = 8'h00;
        model_reset();
        blocks     = 0;
        dut_blocks = 0;
        @(negedge clk);
        reset_cycles(2);

        send_bytes(1'b0, 8'hA0, 16, -1);
        step(1'b0, 1'b0, 8'h00);
        chk("nokey_plain", plain_in, 128'h0);

        send_bytes(1'b1, 8'h01, 16, -1);
        chk("key_load", key, 128'h100F0E0D0C0B0A090807060504030201);

        send_bytes(1'b0, 8'h00, 16, -1);
        chk("plain_val", plain_in, 128'h0F0E0D0C0B0A09080706050403020100);
        repeat (HOLD) step(1'b1, 1'b0, 8'hEE);
        step(1'b0, 1'b0, 8'h00);

        send_bytes(1'b0, 8'h30, 8, 7);
        chk("mm_plain", plain_in, 128'h0F0E0D0C0B0A09080706050403020100);
        send_bytes(1'b0, 8'h40, 16, -1);
        chk("mm_next", plain_in, 128'h4F4E4D4C4B4A49484746454443424140);
        repeat (HOLD) step(1'b0, 1'b0, 8'h00);

        send_bytes(1'b0, 8'h50, 9, -1);
        reset_cycles(2);
        chk("rst_kl", key_loaded, 1'b0);
        send_bytes(1'b1, 8'h01, 16, -1);
        chk("rst_key", key, 128'h100F0E0D0C0B0A090807060504030201);
        send_bytes(1'b0, 8'h60, 16, -1);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        reset_cycles(1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_plain", plain_in, 128'h0);
        send_bytes(1'b1, 8'h20, 16, -1);

        blocks     = 0;
        dut_blocks = 0;
        cyc        = 0;
        while (blocks < 50 && cyc < 20000) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 63) == 0,
                 8'($urandom));
            cyc++;
        end
        chk("rand_blocks", blocks, 50);
        chk("rand_dut_blocks", dut_blocks, 50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_input_loader.md
# aes_input_loader

Byte-serial front end for the AES-128 encrypt top level. It sits directly upstream of that top level. It assembles 16-byte key and plaintext frames from an 8-bit valid/ready stream and drives the top's 128-bit `key` and `plain_in` buses. After each plaintext frame it holds the assembled block stable for a programmable number of cycles, so the encrypt pipeline can consume it before the next block overwrites it.

## Interface
Parameters:
- `HOLD_CYCLES`, default 12: cycles `plain_in` is held stable after `block_start`. Legal range 1–255.

Ports:
- `clk`  in  1  rising-edge clock, single domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  stream byte.
- `in_sel`  in  1  frame type of the byte: 0 = plaintext, 1 = key.
- `in_valid`  in  1  byte present.
- `in_ready`  out  1  loader can accept a byte.
- `key`  out  128  assembled key, to the encrypt top's `key`.
- `plain_in`  out  128  assembled plaintext, to the encrypt top's `plain_in`.
- `key_loaded`  out  1  a complete key frame has been latched since reset (sticky).
- `block_start`  out  1  one-cycle pulse: a new `plain_in` is valid this cycle.
- `busy`  out  1  high in HOLD.
- `frame_err`  out  1  one-cycle pulse: a frame was aborted.

## Operation
- **Transfer rule.** A byte transfers when `in_valid && in_ready` at a rising edge.
- **Byte order.** The byte with index n of a frame (n = 0..15) is written to bits [8n+7:8n], so the first byte lands in bits [7:0]. Example: key bytes 0x01, 0x02, …, 0x10 give `key` = 128'h100F0E0D0C0B0A090807060504030201.
- **Shadow assembly.** Bytes are assembled in a 128-bit shadow register. `key` and `plain_in` update only when a frame completes, never partially.
- **Frame type.** `in_sel` of byte 0 fixes the frame type. If a later byte in the same frame has a different `in_sel`:
  - that byte is consumed and discarded;
  - the frame is dropped;
  - `frame_err` pulses;
  - the byte counter returns to 0;
  - `key` and `plain_in` keep their previous values.
- **Plaintext before key.** A plaintext frame completing while `key_loaded` = 0 is dropped with a `frame_err` pulse. No `block_start` is produced.
- **State machine (`state_t`):**
  - IDLE: `in_ready` = 1, counter = 0. A transfer latches byte 0 and the frame type, then goes to FILL.
  - FILL: `in_ready` = 1. Each transfer increments the counter.
    - Transfer of byte 15 of a key frame: `key` updated, `key_loaded` set, go to IDLE.
    - Transfer of byte 15 of a plaintext frame: `plain_in` updated, `block_start` pulses the next cycle, go to HOLD.
    - Type-mismatch abort: go to IDLE.
  - HOLD: `in_ready` = 0, hold counter counts down from `HOLD_CYCLES`. On reaching 0, go to IDLE.
- **Key updates during a hold.** None are possible, because `in_ready` = 0 in HOLD.
- **Widths.** Byte counter is 4 bits. Hold counter is 8 bits. The counter wraps from 15 to 0 only on frame completion or abort.

## Timing
- **Reset** (`rst_n` = 0 at an edge), applies even mid-frame or mid-HOLD:
  - state = IDLE;
  - `key` = 0, `plain_in` = 0, shadow = 0;
  - `key_loaded` = 0, `block_start` = 0, `busy` = 0, `frame_err` = 0;
  - `in_ready` = 0 during reset and 1 from the first cycle after release;
  - partial frames are discarded.
- **Throughput in IDLE/FILL.** `in_ready` is combinational from state only (not from `in_valid`), so one byte per cycle is accepted.
- **Key frame latency.** Byte 15 transfers at edge T. `key` and `key_loaded` are valid after T.
- **Plaintext frame latency.** Byte 15 transfers at edge T:
  - `plain_in` is valid after T;
  - `block_start` = 1 and `busy` = 1 for the cycle after T;
  - `in_ready` = 0 for exactly `HOLD_CYCLES` cycles after T;
  - the earliest next transfer is at edge T + `HOLD_CYCLES` + 1.
- **`frame_err` timing.** Registered: it is high for the cycle after the aborting transfer.
- **`in_valid` low mid-frame.** The frame stalls and the counter is held. There is no timeout.

## Structure
- Shared package `aes_pkg`:
  - `state_t` enum (IDLE, FILL, HOLD);
  - `AES_BLOCK_BYTES` = 16;
  - `AES_BLOCK_BITS` = 128.
- One sub-module, `byte_shifter`: a 128-bit shadow register with a byte-indexed write enable and a clear input. The FSM and both counters stay in the top level.
- Estimated size: about 180 lines of RTL.

## Test plan
- **Key load.** Reset, then key bytes 0x01..0x10 with `in_sel` = 1 → `key` = 128'h100F0E0D0C0B0A090807060504030201, `key_loaded` = 1, no `block_start`.
- **Plaintext with hold.** After the key, send plaintext bytes 0x00..0x0F with `HOLD_CYCLES` = 12 and `in_valid` held high → `plain_in` = 128'h0F0E0D0C0B0A09080706050403020100, one `block_start` pulse, `in_ready` low for exactly 12 cycles, `plain_in` unchanged throughout.
- **Type mismatch.** Plaintext frame with `in_sel` = 1 on byte 7 → `frame_err` pulses once, `plain_in` unchanged, a following valid 16-byte frame assembles correctly from byte 0.
- **No key loaded.** Plaintext frame immediately after reset → `frame_err` pulses, no `block_start`, `plain_in` = 0.
- **Reset mid-operation.** Assert `rst_n` = 0 during byte 9 of a frame and again during HOLD → all outputs return to reset values, `key_loaded` = 0, and the next frame starts at byte 0.
- **Random gaps.** Randomly toggle `in_valid` across 50 plaintext blocks → every `block_start` matches the reference-model block, and no transfer occurs while `in_ready` = 0.
